mmio_bridge: RTL and testbench
==============================

// Module: mmio_bridge
// PURPOSE
//  Data-side bus bridge between the single-cycle core's memory port and DRAM plus on-board I/O.
//  Decodes each core address as DRAM or MMIO and steers writes to DRAM or to peripheral registers.
//  Muxes the core's read data combinationally, so load data is available in the same cycle.
//  Owns the LED register, the 8-digit hex display register and scanner, switch read-back, and a prescaled 32-bit timer.
// PARAMETERS
//  ADDR_W        14      DRAM word-address width (dram_addr = addr[ADDR_W+1:2])
//  SCAN_DIV      50000   clk cycles per display digit; must be >= 1
//  PRESCALE_RST  1       reset value of the timer prescale register
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       synchronous, active-low reset
//  addr        in   32      core byte address (ALU result)
//  wdata       in   32      core store data (rs2)
//  we          in   1       core store enable
//  rdata       out  32      load data to core writeback mux (combinational)
//  dram_addr   out  ADDR_W  DRAM word address
//  dram_wdata  out  32      DRAM write data (= wdata)
//  dram_we     out  1       DRAM write enable
//  dram_rdata  in   32      DRAM read data (combinational DRAM)
//  sw          in   24      switch inputs
//  led         out  24      LED register
//  dig_en      out  8       one-hot digit select, active-high
//  dig_val     out  4       hex nibble for the selected digit
// BEHAVIOUR
//  Decode: mmio = (addr[31:12] == 20'hFFFFF). addr[1:0] is ignored; all accesses are 32-bit.
//  dram_we = we & ~mmio. dram_addr = addr[ADDR_W+1:2] in all cycles. dram_wdata = wdata.
//  MMIO map, low 12 bits of addr:
//   0x000  DISP   R/W  8 hex digits; digit i = DISP[4i+3:4i]
//   0x020  TCNT   R/W  timer count; a write loads wdata
//   0x024  TPRE   R/W  timer prescale; 0 stops the timer
//   0x060  LED    R/W  bits [23:0]; reads return {8'b0, led}
//   0x070  SW     R    {8'b0, sw}; writes are ignored
//   any other offset: reads return 0, writes are ignored
//  rdata = mmio ? selected register (current, pre-edge value) : dram_rdata. No wait states.
//  Write latency: a register updates on the clk edge that ends the store cycle.
//   A load in the same cycle returns the old value; a load in the next cycle returns the new value.
//  Timer: prescaler pcnt counts 0..TPRE-1. On the cycle where pcnt == TPRE-1, pcnt <= 0 and TCNT <= TCNT+1.
//   TCNT wraps 32'hFFFFFFFF -> 0. TPRE == 0 holds both pcnt and TCNT.
//   A TCNT write in the same cycle as an increment: the write wins (TCNT <= wdata).
//   A TPRE write sets pcnt <= 0. The new TPRE applies from the next cycle.
//  Scanner: scnt counts 0..SCAN_DIV-1. At SCAN_DIV-1, scnt <= 0 and idx <= idx+1 (mod 8).
//   dig_en = 1 << idx, registered. dig_val = DISP[4*idx+3 : 4*idx], combinational.
//   Writes to DISP do not disturb scnt or idx.
//  Reset (rst_n low at a clk edge): led = 0, DISP = 0, TCNT = 0, TPRE = PRESCALE_RST,
//   pcnt = 0, scnt = 0, idx = 0, dig_en = 8'h01.
//   Reset overrides any concurrent store. Reset mid-count abandons the count.
//   DRAM paths are combinational; reset does not gate them, but dram_we still follows we.
// TESTING
//  1. Store 0x00ABCDEF to 0xFFFFF060 -> dram_we = 0; next cycle led = 24'hABCDEF; a load there returns 0x00ABCDEF.
//  2. Store 0x12345678 to 0x00000010 -> dram_we = 1, dram_addr = 4; load 0xFFFFF070 with sw = 24'h00F00F -> rdata = 0x0000F00F.
//  3. TPRE = 3, TCNT = 0 -> TCNT = 1 after 3 clk, 2 after 6; TPRE = 0 -> TCNT frozen for 20 clk.
//  4. Write TCNT = 0xFFFFFFFF with TPRE = 1 -> next increment wraps TCNT to 0.
//     A TCNT write in an increment cycle -> TCNT = wdata.
//  5. SCAN_DIV = 2, DISP = 0x87654321 -> dig_en steps 01, 02, ... 80, 01 every 2 clk; dig_val steps 1, 2, ... 8.
//  6. Assert rst_n = 0 mid-scan with a concurrent LED store -> after the edge, led = 0, dig_en = 01, TPRE = PRESCALE_RST.
//     A load from 0xFFFFF0F0 returns 0.

Source files
------------

// File: rtl/mmio_bridge.sv
// mmio_bridge: core data-port decode to DRAM or MMIO LED/display/switch/timer registers
module mmio_bridge #(
   parameter int          ADDR_W       = 14,
   parameter int          SCAN_DIV     = 50000,
   parameter logic [31:0] PRESCALE_RST = 32'd1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              we,
   output logic [31:0]       rdata,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [31:0]       dram_wdata,
   output logic              dram_we,
   input  logic [31:0]       dram_rdata,
   input  logic [23:0]       sw,
   output logic [23:0]       led,
   output logic [7:0]        dig_en,
   output logic [3:0]        dig_val
);
   localparam int SW_W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   logic [11:0] off;
   logic [31:0] disp, tcnt, tpre, pcnt;
   logic [SW_W-1:0] scnt;
   logic [2:0] idx;
   logic mmio, wr_disp, wr_tcnt, wr_tpre, wr_led, tick, scan_wrap, unused_lsb;
   assign mmio       = addr[31:12] == 20'hFFFFF;
   assign off        = {addr[11:2], 2'b00};
   assign unused_lsb = ^addr[1:0];
   assign dram_addr  = addr[ADDR_W+1:2];
   assign dram_wdata = wdata;
   assign dram_we    = we & ~mmio;
   assign wr_disp    = we & mmio & (off == 12'h000);
   assign wr_tcnt    = we & mmio & (off == 12'h020);
   assign wr_tpre    = we & mmio & (off == 12'h024);
   assign wr_led     = we & mmio & (off == 12'h060);
   assign tick       = (tpre != 32'd0) && (pcnt == tpre - 32'd1);
   assign scan_wrap  = scnt == SW_W'(SCAN_DIV - 1);
   assign dig_val    = disp[{idx, 2'b00} +: 4];
   always_comb begin
      rdata = !mmio           ? dram_rdata :
              off == 12'h000  ? disp :
              off == 12'h020  ? tcnt :
              off == 12'h024  ? tpre :
              off == 12'h060  ? {8'b0, led} :
              off == 12'h070  ? {8'b0, sw} : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led    <= '0;
         disp   <= '0;
         tcnt   <= '0;
         tpre   <= PRESCALE_RST;
         pcnt   <= '0;
         scnt   <= '0;
         idx    <= '0;
         dig_en <= 8'h01;
      end else begin
         if (wr_led) led <= wdata[23:0];
         if (wr_disp) disp <= wdata;
         if (wr_tpre) tpre <= wdata;
         pcnt   <= wr_tpre || tick ? 32'd0 : tpre != 32'd0 ? pcnt + 32'd1 : pcnt;
         tcnt   <= wr_tcnt ? wdata : tick ? tcnt + 32'd1 : tcnt;
         scnt   <= scan_wrap ? '0 : scnt + 1'b1;
         idx    <= scan_wrap ? idx + 3'd1 : idx;
         dig_en <= scan_wrap ? {dig_en[6:0], dig_en[7]} : dig_en;
      end
   end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed tests of decode, LED/switch, timer, scanner and reset
module tb_mmio_bridge;
   logic        clk = 0, rst_n = 0, we = 0;
   logic [31:0] addr = 0, wdata = 0, dram_rdata = 32'hCAFEF00D;
   logic [23:0] sw = 0;
   logic [31:0] rdata, dram_wdata;
   logic [13:0] dram_addr;
   logic        dram_we;
   logic [23:0] led;
   logic [7:0]  dig_en;
   logic [3:0]  dig_val;
   int vecs = 0, errs = 0;

   mmio_bridge #(.ADDR_W(14), .SCAN_DIV(2), .PRESCALE_RST(32'd1)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
      .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we), .dram_rdata(dram_rdata),
      .sw(sw), .led(led), .dig_en(dig_en), .dig_val(dig_val));

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1;
      cyc(1);
      we = 0;
   endtask

   task automatic test_reset;
      rst_n = 0; addr = 32'h40; wdata = 32'h1; we = 1;
      cyc(2);
      vecs++; if (dram_we !== 1'b1) begin errs++; $display("FAIL rst_dram_we got %b exp 1", dram_we); end
      vecs++; if (dram_addr !== 14'h10) begin errs++; $display("FAIL rst_dram_addr got %h exp 0010", dram_addr); end
      vecs++; if (led !== 24'h0) begin errs++; $display("FAIL rst_led got %h exp 000000", led); end
      vecs++; if (dig_en !== 8'h01) begin errs++; $display("FAIL rst_dig_en got %h exp 01", dig_en); end
      we = 0; addr = 32'hFFFFF024; #1;
      vecs++; if (rdata !== 32'h1) begin errs++; $display("FAIL rst_tpre got %h exp 00000001", rdata); end
      addr = 32'hFFFFF000; #1;
      vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_disp got %h exp 00000000", rdata); end
      rst_n = 1;
   endtask

   task automatic test_led;
      addr = 32'hFFFFF060; wdata = 32'h00ABCDEF; we = 1; #1;
      vecs++; if (dram_we !== 1'b0) begin errs++; $display("FAIL led_dram_we got %b exp 0", dram_we); end
      vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL led_old_load got %h exp 00000000", rdata); end
      cyc(1); we = 0; #1;
      vecs++; if (led !== 24'hABCDEF) begin errs++; $display("FAIL led_port got %h exp abcdef", led); end
      vecs++; if (rdata !== 32'h00ABCDEF) begin errs++; $display("FAIL led_load got %h exp 00abcdef", rdata); end
   endtask

   task automatic test_dram_sw;
      addr = 32'h10; wdata = 32'h12345678; we = 1; #1;
      vecs++; if (dram_we !== 1'b1) begin errs++; $display("FAIL dram_we got %b exp 1", dram_we); end
      vecs++; if (dram_addr !== 14'h4) begin errs++; $display("FAIL dram_addr got %h exp 0004", dram_addr); end
      vecs++; if (dram_wdata !== 32'h12345678) begin errs++; $display("FAIL dram_wdata got %h exp 12345678", dram_wdata); end
      vecs++; if (rdata !== 32'hCAFEF00D) begin errs++; $display("FAIL dram_rdata got %h exp cafef00d", rdata); end
      cyc(1); we = 0;
      vecs++; if (led !== 24'hABCDEF) begin errs++; $display("FAIL dram_led_kept got %h exp abcdef", led); end
      sw = 24'h00F00F; addr = 32'hFFFFF070; #1;
      vecs++; if (rdata !== 32'h0000F00F) begin errs++; $display("FAIL sw_read got %h exp 0000f00f", rdata); end
      wr(32'hFFFFF070, 32'hFFFFFFFF); #1;
      vecs++; if (rdata !== 32'h0000F00F) begin errs++; $display("FAIL sw_write_ignored got %h exp 0000f00f", rdata); end
   endtask

   task automatic test_timer;
      wr(32'hFFFFF024, 32'd0);
      wr(32'hFFFFF020, 32'd0);
      wr(32'hFFFFF024, 32'd3);
      addr = 32'hFFFFF020;
      cyc(2);
      vecs++; if (rdata !== 32'd0) begin errs++; $display("FAIL tmr_pre2 got %h exp 00000000", rdata); end
      cyc(1);
      vecs++; if (rdata !== 32'd1) begin errs++; $display("FAIL tmr_3clk got %h exp 00000001", rdata); end
      cyc(3);
      vecs++; if (rdata !== 32'd2) begin errs++; $display("FAIL tmr_6clk got %h exp 00000002", rdata); end
      wr(32'hFFFFF024, 32'd0);
      addr = 32'hFFFFF020;
      cyc(20);
      vecs++; if (rdata !== 32'd2) begin errs++; $display("FAIL tmr_frozen got %h exp 00000002", rdata); end
   endtask

   task automatic test_wrap;
      wr(32'hFFFFF024, 32'd1);
      wr(32'hFFFFF020, 32'hFFFFFFFF);
      addr = 32'hFFFFF020; #1;
      vecs++; if (rdata !== 32'hFFFFFFFF) begin errs++; $display("FAIL tmr_write_wins got %h exp ffffffff", rdata); end
      cyc(1);
      vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL tmr_wrap got %h exp 00000000", rdata); end
      wr(32'hFFFFF020, 32'h100);
      addr = 32'hFFFFF020; #1;
      vecs++; if (rdata !== 32'h100) begin errs++; $display("FAIL tmr_load got %h exp 00000100", rdata); end
      cyc(1);
      vecs++; if (rdata !== 32'h101) begin errs++; $display("FAIL tmr_after_load got %h exp 00000101", rdata); end
   endtask

   task automatic test_scan;
      rst_n = 0; cyc(1); rst_n = 1;
      wr(32'hFFFFF000, 32'h87654321); #1;
      vecs++; if (dig_en !== 8'h01 || dig_val !== 4'h1) begin errs++; $display("FAIL scan_start got %h/%h exp 01/1", dig_en, dig_val); end
      for (int i = 1; i <= 8; i++) begin
         cyc(1);
         vecs++;
         if (dig_en !== 8'(1 << (i % 8)) || dig_val !== 4'((i % 8) + 1)) begin
            errs++; $display("FAIL scan_step%0d got %h/%h exp %h/%h", i, dig_en, dig_val, 8'(1 << (i % 8)), 4'((i % 8) + 1));
         end
         cyc(1);
         vecs++;
         if (dig_en !== 8'(1 << (i % 8))) begin
            errs++; $display("FAIL scan_hold%0d got %h exp %h", i, dig_en, 8'(1 << (i % 8)));
         end
      end
   endtask

   task automatic test_mid_reset;
      wr(32'hFFFFF024, 32'd5);
      vecs++; if (dig_en === 8'h01) begin errs++; $display("FAIL mid_pre_state got %h exp not 01", dig_en); end
      rst_n = 0; addr = 32'hFFFFF060; wdata = 32'h55; we = 1;
      cyc(1);
      rst_n = 1; we = 0;
      vecs++; if (led !== 24'h0) begin errs++; $display("FAIL mid_led got %h exp 000000", led); end
      vecs++; if (dig_en !== 8'h01) begin errs++; $display("FAIL mid_dig_en got %h exp 01", dig_en); end
      addr = 32'hFFFFF024; #1;
      vecs++; if (rdata !== 32'd1) begin errs++; $display("FAIL mid_tpre got %h exp 00000001", rdata); end
      addr = 32'hFFFFF0F0; #1;
      vecs++; if (rdata !== 32'd0) begin errs++; $display("FAIL unmapped_read got %h exp 00000000", rdata); end
      wr(32'hFFFFF0F0, 32'hFFFFFFFF); #1;
      vecs++; if (rdata !== 32'd0 || led !== 24'h0) begin errs++; $display("FAIL unmapped_write got %h/%h exp 00000000/000000", rdata, led); end
   endtask

   initial begin
      test_reset;
      test_led;
      test_dram_sw;
      test_timer;
      test_wrap;
      test_scan;
      test_mid_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
